fb_cmd_controller: RTL

- Command sequencer between the UART receiver and the framebuffer RAM write port; replaces the free-running "every rx byte is the next pixel" write path.
- Parses a small byte protocol from the host (set address, block write, fill screen) and issues single-cycle RAM writes with address wrap at FB_SIZE.
- Hands the rx byte back to the UART with an active-low rx reset pulse.
- Returns an ACK byte through the UART transmitter when each write or fill command completes.

---
 rtl/fb_cmd_pkg.sv | 22 ++
 rtl/fb_rx_byte_accept.sv | 34 +++
 rtl/fb_cmd_controller.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/fb_cmd_pkg.sv
// Shared constants for the framebuffer command sequencer: protocol bytes,
// framebuffer geometry and the FSM state encoding.
package fb_cmd_pkg;

  localparam int FB_SIZE = 9600;

  localparam logic [7:0] CMD_SET_ADDR = 8'hA1;
  localparam logic [7:0] CMD_WRITE    = 8'hA2;
  localparam logic [7:0] CMD_FILL     = 8'hA3;
  localparam logic [7:0] ACK_BYTE     = 8'h06;

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] ADDR_HI  = 4'd1;
  localparam logic [3:0] ADDR_LO  = 4'd2;
  localparam logic [3:0] LEN_HI   = 4'd3;
  localparam logic [3:0] LEN_LO   = 4'd4;
  localparam logic [3:0] DATA     = 4'd5;
  localparam logic [3:0] FILL_VAL = 4'd6;
  localparam logic [3:0] FILL     = 4'd7;
  localparam logic [3:0] ACK      = 4'd8;

endpackage

// File: rtl/fb_rx_byte_accept.sv
// UART rx handshake: flags one byte per rx_ready level and answers it with a
// one-cycle active-low rx reset pulse on the following cycle.
module fb_rx_byte_accept #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  n_reset_i,
  input  logic                  rx_ready_i,
  input  logic [DATA_WIDTH-1:0] rx_data_i,
  input  logic                  enable_i,
  output logic                  byte_valid_o,
  output logic [DATA_WIDTH-1:0] byte_o,
  output logic                  rx_reset_n_o
);

  logic accepted_q;
  logic rx_reset_n_q;

  // rx_ready stays high through the pulse cycle, so the previous acceptance blocks a repeat.
  assign byte_valid_o = rx_ready_i && enable_i && !accepted_q;
  assign byte_o       = rx_data_i;
  assign rx_reset_n_o = rx_reset_n_q;

  always_ff @(posedge clk_i) begin
    if (!n_reset_i) begin
      accepted_q   <= 1'b0;
      rx_reset_n_q <= 1'b1;
    end else begin
      accepted_q   <= byte_valid_o;
      rx_reset_n_q <= !byte_valid_o;
    end
  end

endmodule

// File: rtl/fb_cmd_controller.sv
// Host command sequencer: parses set-address / block-write / fill commands from
// the UART and drives single-cycle framebuffer writes, acking via the UART tx.
module fb_cmd_controller
  import fb_cmd_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  rx_ready,
  input  logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_reset_n,
  input  logic                  tx_ready,
  output logic                  tx_load,
  output logic [7:0]            tx_data,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] write_address,
  output logic [DATA_WIDTH-1:0] ram_in,
  output logic                  busy,
  output logic                  overrun
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(FB_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] SizeAddr = ADDR_WIDTH'(FB_SIZE);

  logic [3:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cursor_q, cursor_d;
  logic [ADDR_WIDTH-1:0] fill_cnt_q, fill_cnt_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] hi_q, hi_d;
  logic [15:0]           len_q, len_d;
  logic [DATA_WIDTH-1:0] fill_val_q, fill_val_d;
  logic [DATA_WIDTH-1:0] ram_in_q, ram_in_d;
  logic                  we_q, we_d;
  logic                  tx_load_q, tx_load_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  overrun_q, overrun_d;
  logic                  busy_q;
  logic                  byte_valid;
  logic [DATA_WIDTH-1:0] byte_data;
  logic [ADDR_WIDTH-1:0] new_addr;

  // Bytes arriving while the ack is pending stay in the UART until IDLE.
  fb_rx_byte_accept #(.DATA_WIDTH(DATA_WIDTH)) u_rx_accept (
    .clk_i       (clk),
    .n_reset_i   (n_reset),
    .rx_ready_i  (rx_ready),
    .rx_data_i   (rx_data),
    .enable_i    (state_q != ACK),
    .byte_valid_o(byte_valid),
    .byte_o      (byte_data),
    .rx_reset_n_o(rx_reset_n)
  );

  always_comb begin
    state_d    = state_q;
    cursor_d   = cursor_q;
    fill_cnt_d = fill_cnt_q;
    waddr_d    = waddr_q;
    hi_d       = hi_q;
    len_d      = len_q;
    fill_val_d = fill_val_q;
    ram_in_d   = ram_in_q;
    we_d       = 1'b0;
    tx_load_d  = 1'b0;
    tx_data_d  = tx_data_q;
    overrun_d  = overrun_q;
    new_addr   = ADDR_WIDTH'({hi_q, byte_data});

    case (state_q)
      IDLE: if (byte_valid) begin
        case (byte_data)
          CMD_SET_ADDR: state_d = ADDR_HI;
          CMD_WRITE:    state_d = LEN_HI;
          CMD_FILL:     state_d = FILL_VAL;
          default:      state_d = IDLE;
        endcase
      end
      ADDR_HI: if (byte_valid) begin
        hi_d    = byte_data;
        state_d = ADDR_LO;
      end
      ADDR_LO: if (byte_valid) begin
        cursor_d = (new_addr >= SizeAddr) ? '0 : new_addr;
        state_d  = IDLE;
      end
      LEN_HI: if (byte_valid) begin
        hi_d    = byte_data;
        state_d = LEN_LO;
      end
      LEN_LO: if (byte_valid) begin
        len_d   = 16'({hi_q, byte_data});
        state_d = (len_d == 16'd0) ? ACK : DATA;
      end
      DATA: if (byte_valid) begin
        we_d     = 1'b1;
        waddr_d  = cursor_q;
        ram_in_d = byte_data;
        cursor_d = (cursor_q == LastAddr) ? '0 : cursor_q + 1'b1;
        len_d    = len_q - 16'd1;
        if (len_q == 16'd1) state_d = ACK;
      end
      FILL_VAL: if (byte_valid) begin
        fill_val_d = byte_data;
        fill_cnt_d = '0;
        state_d    = FILL;
      end
      FILL: begin
        we_d       = 1'b1;
        waddr_d    = fill_cnt_q;
        ram_in_d   = fill_val_q;
        fill_cnt_d = fill_cnt_q + 1'b1;
        if (byte_valid) overrun_d = 1'b1;
        if (fill_cnt_q == LastAddr) begin
          cursor_d = '0;
          state_d  = ACK;
        end
      end
      ACK: if (tx_ready) begin
        tx_load_d = 1'b1;
        tx_data_d = ACK_BYTE;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q    <= IDLE;
      cursor_q   <= '0;
      fill_cnt_q <= '0;
      waddr_q    <= '0;
      hi_q       <= '0;
      len_q      <= '0;
      fill_val_q <= '0;
      ram_in_q   <= '0;
      we_q       <= 1'b0;
      tx_load_q  <= 1'b0;
      tx_data_q  <= '0;
      overrun_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cursor_q   <= cursor_d;
      fill_cnt_q <= fill_cnt_d;
      waddr_q    <= waddr_d;
      hi_q       <= hi_d;
      len_q      <= len_d;
      fill_val_q <= fill_val_d;
      ram_in_q   <= ram_in_d;
      we_q       <= we_d;
      tx_load_q  <= tx_load_d;
      tx_data_q  <= tx_data_d;
      overrun_q  <= overrun_d;
      busy_q     <= (state_d != IDLE);
    end
  end

  assign we            = we_q;
  assign write_address = waddr_q;
  assign ram_in        = ram_in_q;
  assign tx_load       = tx_load_q;
  assign tx_data       = tx_data_q;
  assign overrun       = overrun_q;
  assign busy          = busy_q;

endmodule
